// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard status in, stage enables/flushes out, between datapath and pipeline_ctrl
interface pipeline_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             ex_dREN;
    logic [REG_W-1:0] ex_wsel;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             br_taken;
    logic             id_halt;
    logic             wb_halt;
    logic             pc_en;
    logic             fd_en;
    logic             de_en;
    logic             em_en;
    logic             mw_en;
    logic             fd_flush;
    logic             de_flush;
    logic             imemREN;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ihit, dhit, id_rs, id_rt, ex_dREN, ex_wsel, mem_dREN, mem_dWEN,
               br_taken, id_halt, wb_halt,
        input  pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, imemREN,
               halt, stall_cnt
    );

    modport slave (
        input  ihit, dhit, id_rs, id_rt, ex_dREN, ex_wsel, mem_dREN, mem_dWEN,
               br_taken, id_halt, wb_halt,
        output pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, imemREN,
               halt, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage hazard/halt controller; PIPE_CTRL_PERF_EN adds the stall counter
module pipeline_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t state;
    state_t state_next;

    logic dbusy;
    logic adv;
    logic lu;
    logic pc_en, fd_en, de_en, em_en, mw_en;
    logic fd_flush, de_flush, imem_ren, halt;

    assign dbusy = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;
    assign adv   = bus.ihit & ~dbusy;
    assign lu    = bus.ex_dREN & (bus.ex_wsel != REG_W'(0)) &
                   ((bus.ex_wsel == bus.id_rs) | (bus.ex_wsel == bus.id_rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_next;
    end

    // Outputs are gated by rst so the pipeline freezes the moment reset rises.
    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        fd_en      = 1'b0;
        de_en      = 1'b0;
        em_en      = 1'b0;
        mw_en      = 1'b0;
        fd_flush   = 1'b0;
        de_flush   = 1'b0;
        imem_ren   = 1'b0;
        halt       = 1'b0;
        if (!rst) begin
            case (state)
                S_RUN: begin
                    imem_ren = 1'b1;
                    if (dbusy) begin
                        state_next = S_RUN;
                    end else if (!bus.ihit) begin
                        {de_en, em_en, mw_en} = 3'b111;
                        de_flush = 1'b1;
                    end else if (bus.br_taken) begin
                        {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                    end else if (lu) begin
                        {de_en, em_en, mw_en} = 3'b111;
                        de_flush = 1'b1;
                    end else begin
                        {pc_en, fd_en, de_en, em_en, mw_en} = 5'b11111;
                        if (bus.id_halt) state_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    fd_flush = 1'b1;
                    {de_en, em_en, mw_en} = {3{~dbusy}};
                    // The HALT already in write_back is older than any branch in execute.
                    if (bus.wb_halt) begin
                        state_next = S_HALTED;
                    end else if (bus.br_taken && !dbusy) begin
                        pc_en      = 1'b1;
                        de_flush   = 1'b1;
                        state_next = S_RUN;
                    end
                end
                S_HALTED: begin
                    halt = 1'b1;
                end
                default: begin
                    state_next = S_RUN;
                end
            endcase
        end
    end

    assign bus.pc_en    = pc_en;
    assign bus.fd_en    = fd_en;
    assign bus.de_en    = de_en;
    assign bus.em_en    = em_en;
    assign bus.mw_en    = mw_en;
    assign bus.fd_flush = fd_flush;
    assign bus.de_flush = de_flush;
    assign bus.imemREN  = imem_ren;
    assign bus.halt     = halt;

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state != S_HALTED && !pc_en && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
`endif
endmodule
